// File: rtl/reg_file_if.sv
// Register-file port bundle: one write port, two read ports and the commit counter.
// The datapath side uses master, the register file uses slave.
interface reg_file_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic [15:0]       wr_cnt;

  modport master (
    output we, wa, wd, ra1, ra2,
    input  rd1, rd2, wr_cnt
  );

  modport slave (
    input  we, wa, wd, ra1, ra2,
    output rd1, rd2, wr_cnt
  );
endinterface

// File: rtl/reg_file_32x32.sv
// MIPS general-purpose register file: 32 x 32-bit, two combinational read ports,
// one synchronous write port, $0 hardwired to zero, optional write->read bypass.
module reg_file_32x32 #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter bit BYPASS = 1'b1
) (
  input  logic      clk,
  input  logic      rst,
  reg_file_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [15:0]       wr_cnt_q;
  logic [15:0]       wr_cnt_d;
  logic              wr_commit;

  // A write to $0 is discarded and does not count as a committed write.
  assign wr_commit = !rst && bus.we && (bus.wa != '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wr_cnt_d = wr_cnt_q;
    if (wr_commit && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the array is cleared on reset so every read is defined afterwards;
      // this keeps it in flops rather than a RAM macro, which is fine at 32 entries.
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else if (wr_commit) begin
      // NOTE: non-blocking assignments so all state updates see pre-edge values.
      mem_q[bus.wa] <= bus.wd;
      wr_cnt_q      <= wr_cnt_d;
    end
  end

  always_comb begin
    bus.rd1 = (bus.ra1 == '0) ? '0 : mem_q[bus.ra1];
    if (BYPASS && wr_commit && (bus.wa == bus.ra1)) begin
      bus.rd1 = bus.wd;
    end
  end

  always_comb begin
    bus.rd2 = (bus.ra2 == '0) ? '0 : mem_q[bus.ra2];
    if (BYPASS && wr_commit && (bus.wa == bus.ra2)) begin
      bus.rd2 = bus.wd;
    end
  end

  assign bus.wr_cnt = wr_cnt_q;

endmodule
